// File: rtl/arith_pkg.sv
// Shared ALU definitions: operation encoding and datapath width.
// Imported by the ALU and by every block that drives the ALU's front side.
package arith_pkg;

   localparam int ALU_WIDTH = 32;

   typedef enum logic [3:0] {
      ALU_NONE               = 4'd0,
      ALU_ADD                = 4'd1,
      ALU_SUB                = 4'd2,
      ALU_AND                = 4'd3,
      ALU_OR                 = 4'd4,
      ALU_XOR                = 4'd5,
      ALU_LESS_THAN          = 4'd6,
      ALU_LESS_THAN_UNSIGNED = 4'd7,
      ALU_SHIFT_L            = 4'd8,
      ALU_SHIFT_R            = 4'd9,
      ALU_SHIFT_R_ARITH      = 4'd10
   } alu_operation;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Returns a one-hot grant, its index and whether anything was picked.
module rr_priority_pick #(
   parameter int N    = 2,
   parameter int IDXW = 1
) (
   input  logic [N-1:0]    req,
   input  logic [IDXW-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [IDXW-1:0] idx,
   output logic            any
);

   int pos;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      pos   = 0;
      for (int k = 0; k < N; k++) begin
         pos = (int'(ptr) + k) % N;
         if (!any && req[pos[IDXW-1:0]]) begin
            any                  = 1'b1;
            grant[pos[IDXW-1:0]] = 1'b1;
            idx                  = pos[IDXW-1:0];
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between NUM_REQ requesters.
// Each accepted op is registered once and held until its owner takes it.
module alu_arbiter
   import arith_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int WIDTH   = ALU_WIDTH
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  alu_operation [NUM_REQ-1:0]      req_op,
   input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_a,
   input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_b,
   output logic [NUM_REQ-1:0]              resp_valid,
   input  logic [NUM_REQ-1:0]              resp_ready,
   output logic [WIDTH-1:0]                resp_result,
   output logic [WIDTH-1:0]                alu_a,
   output logic [WIDTH-1:0]                alu_b,
   output alu_operation                    alu_op,
   input  logic [WIDTH-1:0]                alu_result
);

   localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } arb_state_t;

   arb_state_t        state_reg, state_next;
   logic [IDXW-1:0]   owner_reg, owner_next;
   logic [IDXW-1:0]   rr_ptr_reg, rr_ptr_next;
   logic [WIDTH-1:0]  result_reg, result_next;

   logic [NUM_REQ-1:0] pick_grant;
   logic [IDXW-1:0]    pick_idx;
   logic               pick_any;
   logic               retire;
   logic               can_issue;
   logic               accept;

   rr_priority_pick #(
      .N    (NUM_REQ),
      .IDXW (IDXW)
   ) u_pick (
      .req   (req_valid),
      .ptr   (rr_ptr_reg),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // resp_valid is a pure decode of the held state, so it can never disagree with owner.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_resp_valid
      assign resp_valid[gi] = (state_reg == HOLD) && (owner_reg == IDXW'(gi));
   end

   assign resp_result = result_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         owner_reg  <= '0;
         rr_ptr_reg <= '0;
         result_reg <= '0;
      end else begin
         state_reg  <= state_next;
         owner_reg  <= owner_next;
         rr_ptr_reg <= rr_ptr_next;
         result_reg <= result_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      owner_next  = owner_reg;
      rr_ptr_next = rr_ptr_reg;
      result_next = result_reg;
      req_ready   = '0;
      alu_a       = '0;
      alu_b       = '0;
      alu_op      = ALU_NONE;

      retire    = (state_reg == HOLD) && resp_ready[owner_reg];
      can_issue = (state_reg == IDLE) || retire;
      accept    = can_issue && pick_any;

      if (accept) begin
         req_ready   = pick_grant;
         alu_a       = req_a[pick_idx];
         alu_b       = req_b[pick_idx];
         alu_op      = req_op[pick_idx];
         result_next = alu_result;
         owner_next  = pick_idx;
         state_next  = HOLD;
         rr_ptr_next = (pick_idx == IDXW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end else if (retire) begin
         state_next = IDLE;
      end
   end

endmodule
